// File: rtl/sprite_motion_ctrl.sv
// Per-frame position/pop scheduler for the image sprite. All visible outputs
// change together on one edge at the start of vertical blanking.
module sprite_motion_ctrl #(
    parameter int SPRITE_W       = 256,
    parameter int SPRITE_H       = 256,
    parameter int SCREEN_W       = 1280,
    parameter int SCREEN_H       = 720,
    parameter int STEP           = 2,
    parameter int FRAMES_PER_POP = 30
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        enable_in,
    input  logic        load_valid_in,
    input  logic [10:0] load_x_in,
    input  logic [9:0]  load_y_in,
    output logic        load_ready_out,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        pop_out,
    output logic [7:0]  frame_cnt_out,
    output logic        vblank_tick_out
);

    localparam logic [11:0] XMAX       = 12'(SCREEN_W - SPRITE_W);
    localparam logic [10:0] YMAX       = 11'(SCREEN_H - SPRITE_H);
    localparam logic [11:0] STEP_X     = 12'(STEP);
    localparam logic [10:0] STEP_Y     = 11'(STEP);
    localparam logic [7:0]  CNT_LAST   = 8'(FRAMES_PER_POP - 1);
    localparam logic [9:0]  VBLANK_ROW = 10'(SCREEN_H);

    typedef enum logic [0:0] {
        ST_WAIT   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    state_t      state_r;
    logic        dx_pos_r;
    logic        dy_pos_r;
    logic        pending_r;
    logic [10:0] ld_x_r;
    logic [9:0]  ld_y_r;

    logic        tick_s;
    logic        accept_s;
    logic [11:0] x_ext_s;
    logic [10:0] y_ext_s;
    logic [11:0] x_nxt_s;
    logic [10:0] y_nxt_s;
    logic        dx_nxt_s;
    logic        dy_nxt_s;
    logic        pop_nxt_s;
    logic [7:0]  cnt_nxt_s;

    function automatic logic [10:0] clamp_x(input logic [10:0] v);
        if ({1'b0, v} > XMAX) return XMAX[10:0];
        else                  return v;
    endfunction

    function automatic logic [9:0] clamp_y(input logic [9:0] v);
        if ({1'b0, v} > YMAX) return YMAX[9:0];
        else                  return v;
    endfunction

    assign tick_s   = (hcount_in == 11'd0) && (vcount_in == VBLANK_ROW);
    assign accept_s = load_valid_in && load_ready_out;
    assign x_ext_s  = {1'b0, x_out};
    assign y_ext_s  = {1'b0, y_out};

    // Next bounce position/direction on each axis, widened so x+STEP cannot wrap.
    always_comb begin
        x_nxt_s  = x_ext_s;
        dx_nxt_s = dx_pos_r;
        if (dx_pos_r) begin
            if (x_ext_s + STEP_X >= XMAX) begin
                x_nxt_s  = XMAX;
                dx_nxt_s = 1'b0;
            end else begin
                x_nxt_s  = x_ext_s + STEP_X;
            end
        end else begin
            if (x_ext_s <= STEP_X) begin
                x_nxt_s  = 12'd0;
                dx_nxt_s = 1'b1;
            end else begin
                x_nxt_s  = x_ext_s - STEP_X;
            end
        end
    end

    // Same bounce rule for the vertical axis against YMAX.
    always_comb begin
        y_nxt_s  = y_ext_s;
        dy_nxt_s = dy_pos_r;
        if (dy_pos_r) begin
            if (y_ext_s + STEP_Y >= YMAX) begin
                y_nxt_s  = YMAX;
                dy_nxt_s = 1'b0;
            end else begin
                y_nxt_s  = y_ext_s + STEP_Y;
            end
        end else begin
            if (y_ext_s <= STEP_Y) begin
                y_nxt_s  = 11'd0;
                dy_nxt_s = 1'b1;
            end else begin
                y_nxt_s  = y_ext_s - STEP_Y;
            end
        end
    end

    // Frame counter wraps at FRAMES_PER_POP and flips the image select.
    always_comb begin
        pop_nxt_s = pop_out;
        cnt_nxt_s = frame_cnt_out + 8'd1;
        if (frame_cnt_out == CNT_LAST) begin
            pop_nxt_s = ~pop_out;
            cnt_nxt_s = 8'd0;
        end else begin
            pop_nxt_s = pop_out;
        end
    end

    // FSM, registered outputs and load capture.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r         <= ST_WAIT;
            x_out           <= 11'd0;
            y_out           <= 10'd0;
            pop_out         <= 1'b1;
            frame_cnt_out   <= 8'd0;
            vblank_tick_out <= 1'b0;
            load_ready_out  <= 1'b1;
            dx_pos_r        <= 1'b1;
            dy_pos_r        <= 1'b1;
            pending_r       <= 1'b0;
            ld_x_r          <= 11'd0;
            ld_y_r          <= 10'd0;
        end else begin
            vblank_tick_out <= (state_r == ST_UPDATE);
            case (state_r)
                ST_WAIT: begin
                    if (tick_s) state_r <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    state_r <= ST_WAIT;
                    if (pending_r) begin
                        x_out    <= ld_x_r;
                        y_out    <= ld_y_r;
                        dx_pos_r <= 1'b1;
                        dy_pos_r <= 1'b1;
                    end else if (enable_in) begin
                        x_out    <= x_nxt_s[10:0];
                        y_out    <= y_nxt_s[9:0];
                        dx_pos_r <= dx_nxt_s;
                        dy_pos_r <= dy_nxt_s;
                    end
                    if (enable_in) begin
                        pop_out       <= pop_nxt_s;
                        frame_cnt_out <= cnt_nxt_s;
                    end
                end
                default: state_r <= ST_WAIT;
            endcase
            // A load accepted during UPDATE is held for the following frame.
            if ((state_r == ST_UPDATE) && pending_r) begin
                pending_r      <= 1'b0;
                load_ready_out <= 1'b1;
            end else if (accept_s) begin
                pending_r      <= 1'b1;
                load_ready_out <= 1'b0;
                ld_x_r         <= clamp_x(load_x_in);
                ld_y_r         <= clamp_y(load_y_in);
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized scoreboard bench for sprite_motion_ctrl with a frame-level model.
module tb_sprite_motion_ctrl;

    localparam int SW   = 256;
    localparam int SH   = 256;
    localparam int SCW  = 1280;
    localparam int SCH  = 720;
    localparam int STEP = 2;
    localparam int FPP  = 3;
    localparam int XMAX = SCW - SW;
    localparam int YMAX = SCH - SH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        enable;
    logic        load_valid;
    logic [10:0] load_x;
    logic [9:0]  load_y;
    logic        load_ready;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic        pop_o;
    logic [7:0]  frame_cnt_o;
    logic        vblank_tick;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(
        .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(SCW), .SCREEN_H(SCH),
        .STEP(STEP), .FRAMES_PER_POP(FPP)
    ) dut (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .enable_in(enable), .load_valid_in(load_valid), .load_x_in(load_x),
        .load_y_in(load_y), .load_ready_out(load_ready), .x_out(x_o), .y_out(y_o),
        .pop_out(pop_o), .frame_cnt_out(frame_cnt_o), .vblank_tick_out(vblank_tick)
    );

    typedef struct {
        int x;
        int y;
        int pop;
        int cnt;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference state: sprite position/direction, pop state, pending load.
    int m_x, m_y, m_dx, m_dy, m_pop, m_cnt, m_pend, m_ldx, m_ldy, m_upd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_pop = 1; m_cnt = 0;
        m_pend = 0; m_ldx = 0; m_ldy = 0; m_upd = 0;
    endtask

    // Move one coordinate one frame: bounce at 0 and at lim.
    task automatic move(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + STEP >= lim) begin p = lim; d = -1; end
            else p = p + STEP;
        end else begin
            if (p <= STEP) begin p = 0; d = 1; end
            else p = p - STEP;
        end
    endtask

    // One clock: drive inputs, advance the model over the coming edge, sample after it.
    task automatic step(input int h, input int v, input bit en, input bit lv,
                        input int lx, input int ly);
        exp_t e;
        hcount = 11'(h); vcount = 10'(v); enable = en;
        load_valid = lv; load_x = 11'(lx); load_y = 10'(ly);
        if (m_upd != 0) begin
            if (m_pend != 0) begin
                m_x = m_ldx; m_y = m_ldy; m_dx = 1; m_dy = 1;
            end else if (en) begin
                move(m_x, m_dx, XMAX);
                move(m_y, m_dy, YMAX);
            end
            if (en) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == FPP) begin m_cnt = 0; m_pop = 1 - m_pop; end
            end
            e.x = m_x; e.y = m_y; e.pop = m_pop; e.cnt = m_cnt; e.cyc = cyc + 1;
            sb_q.push_back(e);
        end
        if ((m_upd != 0) && (m_pend != 0)) begin
            m_pend = 0;
        end else if (lv && (m_pend == 0)) begin
            m_pend = 1;
            m_ldx = (lx > XMAX) ? XMAX : lx;
            m_ldy = (ly > YMAX) ? YMAX : ly;
        end
        m_upd = ((m_upd == 0) && (h == 0) && (v == SCH)) ? 1 : 0;
        @(posedge clk); #1;
        check("load_ready", int'(load_ready), (m_pend != 0) ? 0 : 1);
    endtask

    task automatic idle(input bit en);
        int h, v;
        h = $urandom_range(0, 1279);
        v = $urandom_range(0, 749);
        if (h == 0 && v == SCH) h = 1;
        step(h, v, en, 1'b0, 0, 0);
    endtask

    task automatic frame(input bit en, input int n_idle);
        repeat (n_idle) idle(en);
        step(0, SCH, en, 1'b0, 0, 0);
        repeat (4) idle(en);
    endtask

    task automatic load(input bit en, input int lx, input int ly);
        step($urandom_range(1, 1279), $urandom_range(0, 719), en, 1'b1, lx, ly);
    endtask

    // Monitor: each vblank pulse must match the oldest expected frame; otherwise outputs hold.
    initial begin
        exp_t e;
        int h_x, h_y, h_pop, h_cnt;
        h_x = 0; h_y = 0; h_pop = 1; h_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                h_x = 0; h_y = 0; h_pop = 1; h_cnt = 0;
            end else if (vblank_tick) begin
                if (sb_q.size() == 0) begin
                    check("vblank_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("frame_cycle", cyc, e.cyc);
                    check("x", int'(x_o), e.x);
                    check("y", int'(y_o), e.y);
                    check("pop", int'(pop_o), e.pop);
                    check("frame_cnt", int'(frame_cnt_o), e.cnt);
                    h_x = e.x; h_y = e.y; h_pop = e.pop; h_cnt = e.cnt;
                end
            end else begin
                check("x_hold", int'(x_o), h_x);
                check("y_hold", int'(y_o), h_y);
                check("pop_hold", int'(pop_o), h_pop);
                check("cnt_hold", int'(frame_cnt_o), h_cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0; hcount = 11'd1; vcount = 10'd0; enable = 1'b1;
        load_valid = 1'b0; load_x = 11'd0; load_y = 10'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", int'(x_o), 0);
        check("rst_y", int'(y_o), 0);
        check("rst_pop", int'(pop_o), 1);
        check("rst_cnt", int'(frame_cnt_o), 0);
        check("rst_vblank", int'(vblank_tick), 0);
        check("rst_ready", int'(load_ready), 1);
        rst_n = 1'b1;

        // Free-running motion from the origin.
        repeat (3) frame(1'b1, 6);
        check("motion_x6", int'(x_o), 6);
        check("motion_y6", int'(y_o), 6);
        check("pop_after3", int'(pop_o), 0);
        check("cnt_after3", int'(frame_cnt_o), 0);

        // Bounce off the right/bottom limits.
        load(1'b1, 1020, 460);
        repeat (4) frame(1'b1, 5);
        check("bounce_x", int'(x_o), 1022);
        check("bounce_y", int'(y_o), 462);

        // Clamped load with valid held across the update.
        for (int i = 0; i < 30; i++) begin
            if (i == 10) step(0, SCH, 1'b1, 1'b1, 2000, 900);
            else step($urandom_range(1, 1279), $urandom_range(0, 719), 1'b1, 1'b1, 2000, 900);
        end
        check("clamp_x", int'(x_o), XMAX);
        check("clamp_y", int'(y_o), YMAX);
        frame(1'b1, 4);

        // Frozen frames still apply a pending load.
        load(1'b0, 300, 100);
        repeat (2) frame(1'b0, 5);
        check("frozen_load_x", int'(x_o), 300);
        check("frozen_load_y", int'(y_o), 100);
        repeat (2) frame(1'b1, 5);
        check("resume_x", int'(x_o), 304);

        // Tick seen on two consecutive cycles yields a single update.
        idle(1'b1);
        step(0, SCH, 1'b1, 1'b0, 0, 0);
        step(0, SCH, 1'b1, 1'b0, 0, 0);
        repeat (4) idle(1'b1);
        step(0, SCH - 1, 1'b1, 1'b0, 0, 0);
        step(1, SCH, 1'b1, 1'b0, 0, 0);
        repeat (3) idle(1'b1);

        // Randomized frames with random enable and loads.
        for (int f = 0; f < 40; f++) begin
            bit en;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                load(en, $urandom_range(0, 2047), $urandom_range(0, 1023));
            frame(en, $urandom_range(2, 12));
        end

        // Asynchronous reset in the middle of a line.
        load(1'b1, 500, 300);
        frame(1'b1, 4);
        check("pre_reset_x", int'(x_o), 500);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_x", int'(x_o), 0);
        check("async_pop", int'(pop_o), 1);
        check("async_vblank", int'(vblank_tick), 0);
        check("async_ready", int'(load_ready), 1);
        model_reset();
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) idle(1'b1);
        repeat (2) frame(1'b1, 5);
        check("post_reset_x", int'(x_o), 4);

        repeat (4) idle(1'b1);
        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
